// File: rtl/shutter_sync_ctrl.sv
// -----------------------------------------------------------------------------
// shutter_sync_ctrl
//   Receiver-side timing core for RF shutter glasses. Measures the spacing of
//   frame-start sync pulses, locks to a stable frame period, and generates
//   left/right shutter timing with dead time around each half-frame boundary.
//   While locked it flywheels through missing pulses. The LCD terminal drive is
//   AC-balanced from a synchronised 1 kHz square wave.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   sync_pe    in   one-cycle sync pulse (frame start, left eye), clk domain
//   ac_sq      in   1 kHz square wave, asynchronous; 2-flop synchronised here
//   shut_l     out  1 = left lens opaque
//   shut_r     out  1 = right lens opaque
//   lcd_l      out  left LCD terminal pair
//   lcd_r      out  right LCD terminal pair
//   locked     out  1 while in LOCKED
//   period     out  current locked period; 0 until the first lock
//   dbg_state  out  FSM state (0 SEARCH, 1 ACQUIRE, 2 LOCKED)
// -----------------------------------------------------------------------------
module shutter_sync_ctrl #(
   parameter int CNT_W      = 16,
   parameter int MIN_PERIOD = 80,
   parameter int MAX_PERIOD = 120,
   parameter int TOL        = 2,
   parameter int LOCK_COUNT = 4,
   parameter int MISS_MAX   = 3,
   parameter int DEAD       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync_pe,
   input  logic             ac_sq,
   output logic             shut_l,
   output logic             shut_r,
   output logic [1:0]       lcd_l,
   output logic [1:0]       lcd_r,
   output logic             locked,
   output logic [CNT_W-1:0] period,
   output logic [1:0]       dbg_state
);

   localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
   localparam int MISS_W  = $clog2(MISS_MAX + 1);

   localparam logic [MATCH_W-1:0] LOCK_N = MATCH_W'(LOCK_COUNT);
   localparam logic [MISS_W-1:0]  MISS_N = MISS_W'(MISS_MAX);
   localparam logic [CNT_W:0]     MIN_M  = (CNT_W + 1)'(MIN_PERIOD);
   localparam logic [CNT_W:0]     MAX_M  = (CNT_W + 1)'(MAX_PERIOD);
   localparam logic [CNT_W:0]     TOL_M  = (CNT_W + 1)'(TOL);
   localparam logic [CNT_W-1:0]   DEAD_C = CNT_W'(DEAD);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     ref_q, ref_d;
   logic [CNT_W-1:0]     phase_q, phase_d;
   logic [CNT_W-1:0]     period_q, period_d;
   logic [MATCH_W-1:0]   match_q, match_d;
   logic [MISS_W-1:0]    miss_q, miss_d;

   logic                 ac_meta_q, ac_s_q;
   logic                 shut_l_q, shut_l_d, shut_r_q, shut_r_d;
   logic [1:0]           lcd_l_q, lcd_l_d, lcd_r_q, lcd_r_d;

   // Spacing measurement carried one bit wider so a saturated counter still
   // yields a correct (out-of-range) spacing and the difference cannot wrap.
   logic [CNT_W:0]       m_w, ref_w, diff_w;
   logic                 valid, consistent;
   logic [CNT_W-1:0]     half;
   logic                 open_l, open_r;

   always_comb begin
      m_w        = {1'b0, cnt_q} + (CNT_W + 1)'(1);
      // While locked the reference is the tracked period itself.
      ref_w      = {1'b0, (state_q == LOCKED) ? period_q : ref_q};
      diff_w     = (m_w >= ref_w) ? (m_w - ref_w) : (ref_w - m_w);
      valid      = (m_w >= MIN_M) && (m_w <= MAX_M);
      consistent = valid && (diff_w <= TOL_M);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      ref_d    = ref_q;
      phase_d  = phase_q;
      period_d = period_q;
      match_d  = match_q;
      miss_d   = miss_q;

      if (sync_pe) cnt_d = '0;

      case (state_q)
         SEARCH: begin
            if (sync_pe) begin
               state_d = ACQUIRE;
               match_d = '0;
            end
         end
         ACQUIRE: begin
            if (sync_pe) begin
               if (!valid) begin
                  state_d = SEARCH;
               end else begin
                  ref_d = m_w[CNT_W-1:0];
                  // A valid but inconsistent spacing starts a new run of one.
                  if ((match_q == '0) || consistent) match_d = match_q + MATCH_W'(1);
                  else                               match_d = MATCH_W'(1);
                  if (match_d == LOCK_N) begin
                     state_d  = LOCKED;
                     period_d = m_w[CNT_W-1:0];
                     phase_d  = '0;
                     miss_d   = '0;
                  end
               end
            end
         end
         LOCKED: begin
            phase_d = phase_q + CNT_W'(1);
            // Inconsistent pulses fall through to the flywheel path untouched.
            // A good pulse on the wrap cycle takes priority over counting a miss.
            if (sync_pe && consistent) begin
               phase_d  = '0;
               miss_d   = '0;
               period_d = m_w[CNT_W-1:0];
            end else if (phase_q == period_q - CNT_W'(1)) begin
               phase_d = '0;
               miss_d  = miss_q + MISS_W'(1);
               if (miss_d == MISS_N) state_d = SEARCH;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_comb begin
      half     = period_q >> 1;
      open_l   = (phase_q >= DEAD_C) && (phase_q < half);
      open_r   = (phase_q >= half + DEAD_C) && (phase_q < period_q);
      shut_l_d = (state_q == LOCKED) && !open_l;
      shut_r_d = (state_q == LOCKED) && !open_r;
      lcd_l_d  = shut_l_q ? {ac_s_q, ~ac_s_q} : {ac_s_q, ac_s_q};
      lcd_r_d  = shut_r_q ? {ac_s_q, ~ac_s_q} : {ac_s_q, ac_s_q};
   end

   // Synchroniser is deliberately unreset so the LCD drive keeps following
   // the square wave while reset is held.
   always_ff @(posedge clk) begin
      ac_meta_q <= ac_sq;
      ac_s_q    <= ac_meta_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= SEARCH;
         cnt_q    <= '0;
         ref_q    <= '0;
         phase_q  <= '0;
         period_q <= '0;
         match_q  <= '0;
         miss_q   <= '0;
         shut_l_q <= 1'b0;
         shut_r_q <= 1'b0;
         lcd_l_q  <= {ac_s_q, ac_s_q};
         lcd_r_q  <= {ac_s_q, ac_s_q};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ref_q    <= ref_d;
         phase_q  <= phase_d;
         period_q <= period_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         shut_l_q <= shut_l_d;
         shut_r_q <= shut_r_d;
         lcd_l_q  <= lcd_l_d;
         lcd_r_q  <= lcd_r_d;
      end
   end

   assign shut_l    = shut_l_q;
   assign shut_r    = shut_r_q;
   assign lcd_l     = lcd_l_q;
   assign lcd_r     = lcd_r_q;
   assign locked    = (state_q == LOCKED);
   assign period    = period_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_shutter_sync_ctrl.sv
module tb_shutter_sync_ctrl;

   localparam int CNT_W = 16;
   localparam int DEAD  = 5;
   localparam logic [1:0] ST_SEARCH  = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   logic             clk;
   logic             rst;
   logic             sync_pe;
   logic             ac_sq;
   logic             shut_l, shut_r;
   logic [1:0]       lcd_l, lcd_r;
   logic             locked;
   logic [CNT_W-1:0] period;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   // expected shutter values from the previous step (drive the LCD model)
   logic prev_l, prev_r;

   logic [CNT_W-1:0] exp_q[$];

   shutter_sync_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .sync_pe   (sync_pe),
      .ac_sq     (ac_sq),
      .shut_l    (shut_l),
      .shut_r    (shut_r),
      .lcd_l     (lcd_l),
      .lcd_r     (lcd_r),
      .locked    (locked),
      .period    (period),
      .dbg_state (dbg_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // one clock: inputs are set before the edge, outputs sampled 1 ns after it
   task automatic step(input logic pe);
      sync_pe = pe;
      @(posedge clk);
      #1;
      sync_pe = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   // Runs n cycles starting just after a phase-0 edge. Pulses every sp cycles,
   // plus an extra one at cycle spur (0 = none). Checks shutters and LCD
   // against the phase model with period per.
   task automatic run_locked(input int n, input int per, input int sp, input int spur);
      int   p;
      int   half;
      logic el, er;
      half = per / 2;
      for (int j = 1; j <= n; j++) begin
         step(((j % sp) == 0) || (j == spur));
         p  = (j - 1) % per;
         el = !((p >= DEAD) && (p < half));
         er = !((p >= half + DEAD) && (p < per));
         check("shut_l", shut_l, el);
         check("shut_r", shut_r, er);
         check("lcd_l", lcd_l, {1'b1, ~prev_l});
         check("lcd_r", lcd_r, {1'b1, ~prev_r});
         check("locked_hold", locked, 1'b1);
         prev_l = el;
         prev_r = er;
      end
   endtask

   int spac[4] = '{101, 99, 100, 102};
   int cur_per;
   logic [CNT_W-1:0] exp_p;

   initial begin
      rst     = 1'b1;
      sync_pe = 1'b0;
      ac_sq   = 1'b1;

      // reset hold with pulses applied; LCD follows the square wave
      for (int i = 0; i < 5; i++) step(i[0]);
      check("rst_lcd_l_hi", lcd_l, 2'b11);
      check("rst_lcd_r_hi", lcd_r, 2'b11);
      ac_sq = 1'b0;
      for (int i = 0; i < 5; i++) step(~i[0]);
      check("rst_lcd_l_lo", lcd_l, 2'b00);
      check("rst_lcd_r_lo", lcd_r, 2'b00);
      check("rst_state", dbg_state, ST_SEARCH);
      check("rst_shut_l", shut_l, 1'b0);
      check("rst_shut_r", shut_r, 1'b0);
      check("rst_locked", locked, 1'b0);
      check("rst_period", period, 16'd0);

      rst   = 1'b0;
      ac_sq = 1'b1;
      gap(4);
      check("unlk_lcd_l", lcd_l, 2'b11);
      check("unlk_state", dbg_state, ST_SEARCH);

      // lock: five pulses 100 apart
      step(1'b1);
      check("acq_state", dbg_state, ST_ACQUIRE);
      for (int k = 0; k < 3; k++) begin
         gap(99);
         step(1'b1);
      end
      check("pre_lock_locked", locked, 1'b0);
      check("pre_lock_state", dbg_state, ST_ACQUIRE);
      gap(99);
      step(1'b1);
      check("lock_locked", locked, 1'b1);
      check("lock_period", period, 16'd100);
      check("lock_state", dbg_state, ST_LOCKED);

      // two frames of shutter pattern, across the wrap
      prev_l = 1'b0;
      prev_r = 1'b0;
      run_locked(200, 100, 100, 0);
      check("frames_period", period, 16'd100);

      // drift tracking
      for (int i = 0; i < 4; i++) exp_q.push_back(CNT_W'(spac[i]));
      cur_per = 100;
      for (int i = 0; i < 4; i++) begin
         run_locked(spac[i], cur_per, spac[i], 0);
         exp_p = exp_q.pop_front();
         check("drift_period", period, exp_p);
         cur_per = spac[i];
      end

      // spurious pulse 30 after a good one: ignored, pattern unchanged
      run_locked(204, 102, 102, 30);
      check("spur_period", period, 16'd102);

      // pulses stop: flywheel for three missed wraps, then unlock
      run_locked(305, 102, 100000, 0);
      step(1'b0);
      check("fly_unlocked", locked, 1'b0);
      check("fly_state", dbg_state, ST_SEARCH);
      check("fly_period_kept", period, 16'd102);
      step(1'b0);
      check("fly_shut_l", shut_l, 1'b0);
      check("fly_shut_r", shut_r, 1'b0);
      step(1'b0);
      check("fly_lcd_l", lcd_l, 2'b11);
      check("fly_lcd_r", lcd_r, 2'b11);

      // relock after five 100-spaced pulses
      gap(20);
      step(1'b1);
      for (int k = 0; k < 3; k++) begin
         gap(99);
         step(1'b1);
      end
      check("relock_pre", locked, 1'b0);
      gap(99);
      step(1'b1);
      check("relock_locked", locked, 1'b1);
      check("relock_period", period, 16'd100);

      // ACQUIRE: 100, 100, 130 -> SEARCH
      rst = 1'b1;
      gap(3);
      rst = 1'b0;
      check("rst2_period", period, 16'd0);
      step(1'b1);
      gap(99); step(1'b1);
      gap(99); step(1'b1);
      check("acq_100_100", dbg_state, ST_ACQUIRE);
      gap(129); step(1'b1);
      check("acq_130_search", dbg_state, ST_SEARCH);

      // ACQUIRE: 100, 60 -> SEARCH
      step(1'b1);
      gap(99); step(1'b1);
      check("acq_100", dbg_state, ST_ACQUIRE);
      gap(59); step(1'b1);
      check("acq_60_search", dbg_state, ST_SEARCH);

      // ACQUIRE: 100, 105 restarts the run; lock needs four 105s
      step(1'b1);
      gap(99); step(1'b1);
      gap(104); step(1'b1);
      gap(104); step(1'b1);
      gap(104); step(1'b1);
      check("restart_no_lock", locked, 1'b0);
      check("restart_state", dbg_state, ST_ACQUIRE);
      gap(104); step(1'b1);
      check("restart_lock", locked, 1'b1);
      check("restart_period", period, 16'd105);

      // pulse coincident with reset is discarded
      rst = 1'b1;
      step(1'b1);
      rst = 1'b0;
      check("rst_pe_state", dbg_state, ST_SEARCH);
      check("rst_pe_locked", locked, 1'b0);
      check("rst_pe_period", period, 16'd0);
      step(1'b0);
      check("rst_pe_state2", dbg_state, ST_SEARCH);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
